// File: rtl/bf_1b_if.sv
// Signal bundle for the bf_1b Boolean function unit: function inputs,
// truth-table load/readback and the registered result.
interface bf_1b_if;
    logic       a;
    logic       b;
    logic       c;
    logic       tt_we;
    logic [7:0] tt_wdata;
    logic [7:0] tt_rdata;
    logic       x;

    modport master (
        output a, b, c, tt_we, tt_wdata,
        input  tt_rdata, x
    );

    modport slave (
        input  a, b, c, tt_we, tt_wdata,
        output tt_rdata, x
    );
endinterface

// File: rtl/bf_1b.sv
// 1-bit, 3-input Boolean function unit: x = tt[{a,b,c}], registered, with a reloadable table.
// Optional INPUT_SYNC_EN adds a 2-flop synchronizer on a/b/c (3 clk input-to-x latency).
module bf_1b #(
    parameter logic [7:0] DEFAULT_TT = 8'hCA
) (
    input  logic   clk,
    input  logic   rst_n,
    bf_1b_if.slave bus
);

    logic [7:0] tt_q, tt_d;
    logic       x_q, x_d;
    logic [2:0] idx;

`ifdef INPUT_SYNC_EN
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = {bus.a, bus.b, bus.c};
        sync2_d = sync1_q;
        idx     = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end
`else
    always_comb begin
        idx = {bus.a, bus.b, bus.c};
    end
`endif

    // Output reads tt_q (pre-edge table), so a same-edge write affects only later edges.
    always_comb begin
        tt_d = tt_q;
        if (bus.tt_we) begin
            tt_d = bus.tt_wdata;
        end
        x_d = tt_q[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tt_q <= DEFAULT_TT;
            x_q  <= 1'b0;
        end else begin
            tt_q <= tt_d;
            x_q  <= x_d;
        end
    end

    assign bus.tt_rdata = tt_q;
    assign bus.x        = x_q;

endmodule

// File: tb/tb_bf_1b.sv
// Directed self-checking bench for bf_1b; honours INPUT_SYNC_EN for latency.
module tb_bf_1b;

`ifdef INPUT_SYNC_EN
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned LAT = 1;
`endif

    localparam logic [7:0] TT_DEF = 8'hCA;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bf_1b_if bus ();

    bf_1b #(.DEFAULT_TT(8'hCA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_abc(input logic [2:0] v);
        bus.a = v[2];
        bus.b = v[1];
        bus.c = v[0];
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus.tt_we    = 1'b0;
        bus.tt_wdata = 8'h00;
        set_abc(3'b111);
        step(2);
        checks++;
        if (bus.x !== 1'b0) begin
            errors++;
            $display("FAIL reset_x got %b exp 0", bus.x);
        end
        checks++;
        if (bus.tt_rdata !== TT_DEF) begin
            errors++;
            $display("FAIL reset_tt got %h exp %h", bus.tt_rdata, TT_DEF);
        end
        rst_n = 1'b1;
        step(LAT);
        checks++;
        if (bus.x !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_x got %b exp 1", bus.x);
        end
    endtask

    task automatic test_default_sweep;
        logic [7:0] exp_seq;
        exp_seq = 8'b1100_1010;
        for (int i = 0; i < 8; i++) begin
            set_abc(3'(i));
            step(LAT);
            checks++;
            if (bus.x !== exp_seq[i]) begin
                errors++;
                $display("FAIL sweep_idx%0d got %b exp %b", i, bus.x, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reload;
        set_abc(3'b011);
        step(LAT - 1);
        bus.tt_we    = 1'b1;
        bus.tt_wdata = 8'h96;
        step(1);
        bus.tt_we    = 1'b0;
        checks++;
        if (bus.x !== 1'b1) begin
            errors++;
            $display("FAIL reload_old_table got %b exp 1", bus.x);
        end
        checks++;
        if (bus.tt_rdata !== 8'h96) begin
            errors++;
            $display("FAIL reload_rdata got %h exp 96", bus.tt_rdata);
        end
        step(1);
        checks++;
        if (bus.x !== 1'b0) begin
            errors++;
            $display("FAIL reload_new_table got %b exp 0", bus.x);
        end
    endtask

    task automatic test_async_rate;
        logic [2:0] hist [3];
        bus.tt_we    = 1'b1;
        bus.tt_wdata = TT_DEF;
        set_abc(3'b000);
        step(1);
        bus.tt_we = 1'b0;
        step(3);
        for (int k = 0; k < 3; k++) hist[k] = 3'b000;
        @(negedge clk);
        fork
            begin
                repeat (50) begin
                    #20 bus.a = ~bus.a;
                end
            end
            begin
                repeat (33) begin
                    #30 bus.b = ~bus.b;
                end
            end
            begin
                repeat (25) begin
                    #40 bus.c = ~bus.c;
                end
            end
            begin
                repeat (100) begin
                    @(posedge clk);
                    hist[2] = hist[1];
                    hist[1] = hist[0];
                    hist[0] = {bus.a, bus.b, bus.c};
                    #1;
                    checks++;
                    if (bus.x !== TT_DEF[hist[LAT-1]]) begin
                        errors++;
                        $display("FAIL async_rate t=%0t got %b exp %b", $time, bus.x, TT_DEF[hist[LAT-1]]);
                    end
                end
            end
        join
    endtask

    task automatic test_midrun_reset;
        bus.tt_we    = 1'b1;
        bus.tt_wdata = 8'hFF;
        step(1);
        bus.tt_we = 1'b0;
        set_abc(3'b100);
        step(LAT);
        checks++;
        if (bus.x !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre_reset_x got %b exp 1", bus.x);
        end
        rst_n        = 1'b0;
        bus.tt_we    = 1'b1;
        bus.tt_wdata = 8'h55;
        step(1);
        checks++;
        if (bus.x !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_x got %b exp 0", bus.x);
        end
        checks++;
        if (bus.tt_rdata !== TT_DEF) begin
            errors++;
            $display("FAIL midrun_reset_tt got %h exp %h", bus.tt_rdata, TT_DEF);
        end
        bus.tt_we = 1'b0;
        rst_n     = 1'b1;
        step(LAT);
        checks++;
        if (bus.x !== 1'b0) begin
            errors++;
            $display("FAIL midrun_after_reset_x got %b exp 0", bus.x);
        end
    endtask

`ifdef INPUT_SYNC_EN
    task automatic test_sync_latency;
        logic [2:0] exp_x;
        exp_x = 3'b100;
        set_abc(3'b000);
        step(4);
        set_abc(3'b001);
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (bus.x !== exp_x[i]) begin
                errors++;
                $display("FAIL sync_latency_edge%0d got %b exp %b", i + 1, bus.x, exp_x[i]);
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_default_sweep();
        test_reload();
        test_async_rate();
        test_midrun_reset();
`ifdef INPUT_SYNC_EN
        test_sync_latency();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
